wb_debug_master: RTL and testbench

- Byte-stream-driven Wishbone initiator that drives the SoC front port (third arbiter master).
- Lets a host read and write any mapped address (IMEM, DMEM, UART, GPIO) over a serial link.
- Consumes bytes from a UART receiver and returns status and data bytes to a UART transmitter.
- Issues single classic-cycle 32-bit transfers and guards each transfer with an ack timeout.

---
 rtl/wb_debug_master_pkg.sv | 17 +
 rtl/wb_debug_master_bytepack.sv | 40 ++++
 rtl/wb_debug_master.sv | 198 +++++++++++++++++++
 tb/tb_wb_debug_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_debug_master_pkg.sv
// Shared constants and FSM encoding for the byte-stream Wishbone debug master.
package wb_debug_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/wb_debug_master_bytepack.sv
// 32-bit little-endian byte pack/unpack register with a 2-bit byte index.
// Used to assemble the address and write data, and to serialise read data.
module wb_debug_bytepack (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        rewind,     // restart at byte 0, contents kept
  input  logic        wr,         // store wr_byte at the current index, advance
  input  logic [7:0]  wr_byte,
  input  logic        load,       // parallel load, index back to byte 0
  input  logic [31:0] load_word,
  input  logic        adv,        // advance the index without writing
  output logic [31:0] word,
  output logic [1:0]  idx
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // Word and index register; load takes priority over rewind, write, advance.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= load_word;
      idx_q  <= '0;
    end else if (rewind) begin
      idx_q <= '0;
    end else if (wr) begin
      word_q[{idx_q, 3'b000} +: 8] <= wr_byte;
      idx_q                        <= idx_q + 2'd1;
    end else if (adv) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  assign word = word_q;
  assign idx  = idx_q;

endmodule

// File: rtl/wb_debug_master.sv
// Serial-command Wishbone initiator: parses W/R frames from a byte stream,
// runs one classic 32-bit cycle guarded by an ack timeout, returns status/data.
module wb_debug_master
  import wb_debug_master_pkg::*;
#(
  parameter int ACK_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 100000,
  parameter int CNT_W         = 17
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_vld_i,
  output logic [7:0]  tx_dat_o,
  output logic        tx_vld_o,
  input  logic        tx_rdy_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [7:0]       status_q, status_d;
  logic             ok_q, ok_d;
  logic             phase_q, phase_d;     // 0: status byte, 1: read-data bytes
  logic             overrun_q, overrun_d;

  logic        frame_rewind, adr_wr, dat_wr, rd_load, rd_adv;
  logic [31:0] adr_word, dat_word, rd_word;
  logic [1:0]  adr_idx, dat_idx, rd_idx;
  logic        in_bus;

  wb_debug_bytepack u_adr (
    .clk_i     (wb_clk_i),
    .rst_n     (wb_rst_i),
    .rewind    (frame_rewind),
    .wr        (adr_wr),
    .wr_byte   (rx_dat_i),
    .load      (1'b0),
    .load_word ('0),
    .adv       (1'b0),
    .word      (adr_word),
    .idx       (adr_idx)
  );

  wb_debug_bytepack u_wdat (
    .clk_i     (wb_clk_i),
    .rst_n     (wb_rst_i),
    .rewind    (frame_rewind),
    .wr        (dat_wr),
    .wr_byte   (rx_dat_i),
    .load      (1'b0),
    .load_word ('0),
    .adv       (1'b0),
    .word      (dat_word),
    .idx       (dat_idx)
  );

  wb_debug_bytepack u_rdat (
    .clk_i     (wb_clk_i),
    .rst_n     (wb_rst_i),
    .rewind    (1'b0),
    .wr        (1'b0),
    .wr_byte   (8'h00),
    .load      (rd_load),
    .load_word (wb_dat_i),
    .adv       (rd_adv),
    .word      (rd_word),
    .idx       (rd_idx)
  );

  // FSM state and control registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      status_q  <= '0;
      ok_q      <= 1'b0;
      phase_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      status_q  <= status_d;
      ok_q      <= ok_d;
      phase_q   <= phase_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state, shared timeout counter and pack-register controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    status_d     = status_q;
    ok_d         = ok_q;
    phase_d      = phase_q;
    overrun_d    = overrun_q;
    frame_rewind = 1'b0;
    adr_wr       = 1'b0;
    dat_wr       = 1'b0;
    rd_load      = 1'b0;
    rd_adv       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_vld_i && (rx_dat_i == CMD_WRITE || rx_dat_i == CMD_READ)) begin
          we_d         = (rx_dat_i == CMD_WRITE);
          frame_rewind = 1'b1;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_vld_i) begin
          adr_wr = 1'b1;
          cnt_d  = '0;
          if (adr_idx == 2'd3) state_d = we_q ? ST_DATA : ST_BUS;
        end else if (cnt_q == FRAME_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_vld_i) begin
          dat_wr = 1'b1;
          cnt_d  = '0;
          if (dat_idx == 2'd3) state_d = ST_BUS;
        end else if (cnt_q == FRAME_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUS: begin
        if (rx_vld_i) overrun_d = 1'b1;
        // Ack wins over a timeout expiring in the same cycle.
        if (wb_ack_i) begin
          status_d = RSP_ACK;
          ok_d     = 1'b1;
          rd_load  = !we_q;
          phase_d  = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == ACK_LAST) begin
          status_d = RSP_NAK;
          ok_d     = 1'b0;
          phase_d  = 1'b0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d = '0;
        if (rx_vld_i) overrun_d = 1'b1;
        if (tx_rdy_i) begin
          if (!phase_q) begin
            if (ok_q && !we_q) phase_d = 1'b1;
            else               state_d = ST_IDLE;
          end else begin
            rd_adv = 1'b1;
            if (rd_idx == 2'd3) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_bus    = (state_q == ST_BUS);
  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = in_bus;
  assign wb_we_o   = in_bus & we_q;
  assign wb_sel_o  = in_bus ? 4'hF : 4'h0;
  assign wb_adr_o  = adr_word;
  assign wb_dat_o  = dat_word;
  assign tx_vld_o  = (state_q == ST_RESP);
  assign tx_dat_o  = !tx_vld_o ? 8'h00 :
                     phase_q   ? rd_word[{rd_idx, 3'b000} +: 8] : status_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_wb_debug_master.sv
// Self-checking bench for wb_debug_master: directed scenarios plus random
// write/read-back traffic checked against a behavioural memory model.
module tb_wb_debug_master;

  localparam int ACK_TO   = 40;
  localparam int FRAME_TO = 300;
  localparam int BUDGET   = ACK_TO + 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_vld = 1'b0;
  logic [7:0]  tx_dat;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = '0;
  logic        we, stb, cyc;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic        busy, overrun;

  always #5 clk = ~clk;

  wb_debug_master #(.ACK_TIMEOUT(ACK_TO), .FRAME_TIMEOUT(FRAME_TO), .CNT_W(17)) dut (
    .wb_clk_i (clk),    .wb_rst_i (rst_n),
    .rx_dat_i (rx_dat), .rx_vld_i (rx_vld),
    .tx_dat_o (tx_dat), .tx_vld_o (tx_vld), .tx_rdy_i (tx_rdy),
    .wb_adr_o (adr),    .wb_dat_o (dat_o),  .wb_dat_i (dat_i),
    .wb_we_o  (we),     .wb_sel_o (sel),    .wb_stb_o (stb),
    .wb_cyc_o (cyc),    .wb_ack_i (ack),
    .busy_o   (busy),   .overrun_o (overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Contents returned for never-written addresses (environment rule).
  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  // ---------------- Wishbone slave model ----------------
  bit          slave_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          cyc_cnt = 0;
  int          acks = 0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;
  logic [31:0] mem [logic [31:0]];

  always @(negedge clk) begin
    ack = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (cyc && stb) begin
      cyc_cnt++;
      if (slave_en && wait_cnt == ack_delay) begin
        ack = 1'b1;
        wait_cnt = 0;
        acks++;
        cap_adr = adr; cap_dat = dat_o; cap_we = we; cap_sel = sel;
        if (we) mem[adr] = dat_o;
        else    dat_i = mem.exists(adr) ? mem[adr] : fill(adr);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // ---------------- host-side tasks (entered at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_dat = b;
    rx_vld = 1'b1;
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic get_byte(input int hold, output logic [7:0] b);
    int n = 0;
    logic [7:0] first;
    bit stable = 1'b1;
    while (!tx_vld && n < BUDGET) begin @(negedge clk); n++; end
    check("tx_vld_wait", 32'(tx_vld), 32'd1);
    first = tx_dat;
    repeat (hold) begin
      @(negedge clk);
      if (tx_dat !== first || tx_vld !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check("tx_hold_stable", 32'(stable), 32'd1);
    b = tx_dat;
    tx_rdy = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input int delay, input int hold);
    int base_c = cyc_cnt;
    int base_a = acks;
    logic [7:0] b;
    ack_delay = delay;
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    check("wr_start_latency", 32'(cyc), 32'd1);
    get_byte(hold, b);
    check("wr_status", 32'(b), 32'h06);
    check("wr_adr", cap_adr, a);
    check("wr_dat", cap_dat, d);
    check("wr_we", 32'(cap_we), 32'd1);
    check("wr_sel", 32'(cap_sel), 32'hF);
    check("wr_one_cycle", 32'(acks - base_a), 32'd1);
    check("wr_cyc_len", 32'(cyc_cnt - base_c), 32'(delay + 1));
    check("wr_busy_end", 32'(busy), 32'd0);
    ref_mem[a] = d;
  endtask

  task automatic run_read(input logic [31:0] a, input int delay, input int hold, input bit inject);
    logic [31:0] exp = ref_read(a);
    int base_c = cyc_cnt;
    logic [7:0] b;
    ack_delay = delay;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    check("rd_start_latency", 32'(cyc), 32'd1);
    if (inject) begin
      send_byte(8'h57);
      check("overrun_set", 32'(overrun), 32'd1);
    end
    get_byte(hold, b);
    check("rd_status", 32'(b), 32'h06);
    for (int i = 0; i < 4; i++) begin
      get_byte(hold, b);
      check("rd_data_byte", 32'(b), 32'(exp[8*i +: 8]));
    end
    check("rd_adr", cap_adr, a);
    check("rd_we", 32'(cap_we), 32'd0);
    check("rd_cyc_len", 32'(cyc_cnt - base_c), 32'(delay + 1));
    check("rd_busy_end", 32'(busy), 32'd0);
    check("rd_no_extra_tx", 32'(tx_vld), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] ra, rd;
    int          base_c, n;

    // Reset state.
    #1;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_tx", {23'd0, tx_vld, tx_dat}, 32'd0);
    check("rst_busy_ovr", {30'd0, busy, overrun}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write, then read with slow transmitter.
    run_write(32'h0001_0000, 32'hDEAD_BEEF, 2, 0);
    run_write(32'h0000_0004, 32'h1234_5678, 0, 0);
    run_read(32'h0000_0004, 1, 10, 1'b0);
    check("overrun_clear", 32'(overrun), 32'd0);

    // Ack timeout.
    slave_en = 1'b0;
    base_c = cyc_cnt;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    check("to_start_latency", 32'(cyc), 32'd1);
    n = 0;
    while (!tx_vld && n < BUDGET) begin @(negedge clk); n++; end
    check("to_cyc_len", 32'(cyc_cnt - base_c), 32'(ACK_TO));
    check("to_busy_pending", 32'(busy), 32'd1);
    get_byte(3, b);
    check("to_status", 32'(b), 32'h15);
    check("to_no_data", 32'(tx_vld), 32'd0);
    check("to_busy_end", 32'(busy), 32'd0);
    slave_en = 1'b1;

    // Garbage byte, then an abandoned frame.
    base_c = cyc_cnt;
    send_byte(8'h41);
    check("garbage_idle", 32'(busy), 32'd0);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h11);
    check("partial_busy", 32'(busy), 32'd1);
    repeat (FRAME_TO + 5) @(negedge clk);
    check("frame_to_idle", 32'(busy), 32'd0);
    check("frame_to_no_cycle", 32'(cyc_cnt - base_c), 32'd0);
    run_read(32'h0000_0040, 0, 0, 1'b0);

    // Overrun during BUS; flag is sticky and parser unaffected.
    run_read(32'h0001_0000, 5, 0, 1'b1);
    run_write(32'h0000_0100, 32'hCAFE_F00D, 1, 0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Random traffic with read-back.
    for (int k = 0; k < 6; k++) begin
      ra = $urandom & 32'h0000_FFFC;
      rd = $urandom;
      run_write(ra, rd, $urandom_range(0, 4), $urandom_range(0, 3));
      run_read(ra, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
      run_read($urandom & 32'h00FF_FFFC, $urandom_range(0, 3), 0, 1'b0);
    end

    // Reset in the middle of a bus cycle.
    slave_en = 1'b0;
    send_byte(8'h52);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(negedge clk);
    check("pre_rst_cyc", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("mid_rst_tx_vld", 32'(tx_vld), 32'd0);
    check("mid_rst_busy_ovr", {30'd0, busy, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    @(negedge clk);
    check("post_rst_no_tx", 32'(tx_vld), 32'd0);
    run_write(32'h0000_0200, 32'h0BAD_C0DE, 2, 1);
    run_read(32'h0000_0200, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
